// File: rtl/axil_sram_responder.sv
// AXI-Lite responder in front of a word-organised SRAM, with independent read and write FSMs.
// Define RAND_DELAY_EN to add LFSR-driven extra latency and ready backpressure.
module axil_sram_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 5;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  // Out-of-range outranks misalignment.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if (addr < BASE_ADDR || off >= SPAN) decode_resp = RESP_DECERR;
    else if (addr[1:0] != 2'b00)         decode_resp = RESP_SLVERR;
    else                                 decode_resp = RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [CNT_W-1:0] extra_c;
  logic             ready_gate_c;

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign extra_c      = CNT_W'(lfsr[2:0]);
  assign ready_gate_c = lfsr[3];
`else
  assign extra_c      = '0;
  assign ready_gate_c = 1'b1;
`endif

  // ---------------- read channel ----------------
  r_state_t         r_state, r_state_d;
  logic [CNT_W-1:0] r_cnt, r_cnt_d;
  logic [31:0]      r_addr, r_addr_d;
  logic             arready_d, rvalid_d;
  logic [31:0]      rdata_d;
  logic [1:0]       rresp_d, r_resp_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_addr  <= r_addr_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state;
    r_cnt_d   = r_cnt;
    r_addr_d  = r_addr;
    arready_d = arready;
    rvalid_d  = rvalid;
    rdata_d   = rdata;
    rresp_d   = rresp;
    r_resp_c  = decode_resp(r_addr);
    case (r_state)
      R_IDLE: begin
        arready_d = ready_gate_c;
        if (arvalid && arready) begin
          r_addr_d  = araddr;
          arready_d = 1'b0;
          r_cnt_d   = RD_LAT + extra_c;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt == '0) begin
          rdata_d   = (r_resp_c == RESP_OKAY) ? mem[word_idx(r_addr)] : '0;
          rresp_d   = r_resp_c;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = ready_gate_c;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------- write channel ----------------
  w_state_t         w_state, w_state_d;
  logic [CNT_W-1:0] w_cnt, w_cnt_d;
  logic [31:0]      w_addr, w_addr_d, w_data, w_data_d;
  logic [3:0]       w_strb, w_strb_d;
  logic             aw_got, aw_got_d, w_got, w_got_d;
  logic             awready_d, wready_d, bvalid_d;
  logic [1:0]       bresp_d, w_resp_c;
  logic             aw_hs_c, w_hs_c, mem_we_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
    end else begin
      w_state <= w_state_d;
      w_cnt   <= w_cnt_d;
      w_addr  <= w_addr_d;
      w_data  <= w_data_d;
      w_strb  <= w_strb_d;
      aw_got  <= aw_got_d;
      w_got   <= w_got_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state;
    w_cnt_d   = w_cnt;
    w_addr_d  = w_addr;
    w_data_d  = w_data;
    w_strb_d  = w_strb;
    aw_got_d  = aw_got;
    w_got_d   = w_got;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    mem_we_c  = 1'b0;
    aw_hs_c   = awvalid && awready;
    w_hs_c    = wvalid && wready;
    w_resp_c  = decode_resp(w_addr);
    case (w_state)
      W_IDLE: begin
        // Address and data phases complete independently, in either order.
        if (aw_hs_c) begin
          w_addr_d = awaddr;
          aw_got_d = 1'b1;
        end
        if (w_hs_c) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          w_got_d  = 1'b1;
        end
        awready_d = !aw_got_d && ready_gate_c;
        wready_d  = !w_got_d && ready_gate_c;
        if (aw_got_d && w_got_d) begin
          w_cnt_d   = WR_LAT + extra_c;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt == '0) begin
          mem_we_c  = (w_resp_c == RESP_OKAY);
          bresp_d   = w_resp_c;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = ready_gate_c;
          wready_d  = ready_gate_c;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Array is never reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Randomised self-checking bench for axil_sram_responder against an address-map/array reference model.
module tb_axil_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RL    = 2;
  localparam int          WL    = 3;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [int];

  axil_sram_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = a; lo = BASE; hi = lo + 4 * DEPTH;
    if (la < lo || la >= hi) return 2'b11;
    if (la % 4 != 0)         return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (ref_resp(a) != 2'b00) return;
    w = ref_mem.exists(ref_idx(a)) ? ref_mem[ref_idx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[ref_idx(a)] = w;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_resp(a) != 2'b00) return 32'h0;
    return ref_mem.exists(ref_idx(a)) ? ref_mem[ref_idx(a)] : 32'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit ack, output logic [1:0] r, output int lat);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0; n = 0; lat = -1; r = 2'b01;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step(); n++;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  wvalid = 1'b0;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) return;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) return;
    lat = n; r = bresp;
    ref_write(a, d, s);
    if (ack) begin bready = 1'b1; step(); bready = 1'b0; end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
    int n;
    d = 32'h0; r = 2'b01; lat = -1; n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    if (!arready) begin arvalid = 1'b0; return; end
    step(); arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    if (!rvalid) return;
    lat = n; d = rdata; r = rresp;
    rready = 1'b1; step(); rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {arready, awready, wready, rvalid, bvalid});
    end
    checks++;
    if ({rdata, rresp, bresp} !== 36'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {rdata, rresp, bresp});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b want 111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b want 00", r); end
    checks++; if (lat !== WL + 1) begin errors++; $display("FAIL basic_wlat: got %0d want %0d", lat, WL + 1); end
    axi_read(BASE + 32'h10, d, r, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h want deadbeef", d); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_rresp: got %b want 00", r); end
    checks++; if (lat !== RL + 1) begin errors++; $display("FAIL basic_rlat: got %0d want %0d", lat, RL + 1); end
  endtask

  task automatic test_partial();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(BASE + 32'h10, 32'h1122_3344, 4'b0101, 1'b1, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL partial_bresp: got %b want 00", r); end
    axi_read(BASE + 32'h10, d, r, lat);
    checks++;
    if (d !== ref_read(BASE + 32'h10)) begin
      errors++; $display("FAIL partial_rdata: got %h want %h", d, ref_read(BASE + 32'h10));
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] a, v, d; logic [1:0] r; int n, lat;
    a = BASE + 32'h20; v = $urandom;
    wdata = v; wstrb = 4'hF; wvalid = 1'b1; n = 0;
    while (!wready && n < 50) begin step(); n++; end
    step(); wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({awready, wready, bvalid} !== 3'b100) begin
        errors++; $display("FAIL wfirst_ready_c%0d: got %b want 100", k, {awready, wready, bvalid});
      end
      step();
    end
    awaddr = a; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin step(); n++; end
    step(); awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    lat = bvalid ? n : -1;
    checks++; if (lat !== WL + 1) begin errors++; $display("FAIL wfirst_blat: got %0d want %0d", lat, WL + 1); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL wfirst_bresp: got %b want 00", bresp); end
    ref_write(a, v, 4'hF);
    bready = 1'b1; step(); bready = 1'b0;
    axi_read(a, d, r, lat);
    checks++; if (d !== ref_read(a)) begin errors++; $display("FAIL wfirst_rdata: got %h want %h", d, ref_read(a)); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [9];
    bit          wrs   [9];
    logic [3:0]  strbs [9];
    logic [31:0] d, v; logic [1:0] r; int lat;
    addrs = '{BASE, BASE + 32'h1000, BASE + 32'h2, BASE, BASE + 32'h5,
              BASE + 32'h1002, BASE - 32'h4, BASE, BASE + 32'hFFC};
    wrs   = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
    strbs = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
    for (int i = 0; i < 9; i++) begin
      v = $urandom;
      if (wrs[i]) axi_write(addrs[i], v, strbs[i], 1'b1, r, lat);
      else        axi_read(addrs[i], d, r, lat);
      checks++;
      if (r !== ref_resp(addrs[i])) begin
        errors++; $display("FAIL err_resp_%0d: addr %h got %b want %b", i, addrs[i], r, ref_resp(addrs[i]));
      end
      if (!wrs[i]) begin
        checks++;
        if (d !== ref_read(addrs[i])) begin
          errors++; $display("FAIL err_rdata_%0d: addr %h got %h want %h", i, addrs[i], d, ref_read(addrs[i]));
        end
      end
    end
    // Base word after the misaligned and zero-strobe writes.
    axi_read(BASE, d, r, lat);
    checks++; if (d !== ref_read(BASE)) begin errors++; $display("FAIL err_base_intact: got %h want %h", d, ref_read(BASE)); end
    axi_read(BASE + 32'hFFC, d, r, lat);
    checks++; if (d !== ref_read(BASE + 32'hFFC)) begin errors++; $display("FAIL err_last_word: got %h want %h", d, ref_read(BASE + 32'hFFC)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, exp_d; int n;
    a = BASE + 32'h10; exp_d = ref_read(a);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step(); arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    checks++; if (n !== RL + 1) begin errors++; $display("FAIL bp_rlat: got %0d want %0d", n, RL + 1); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, exp_d}) begin
        errors++; $display("FAIL bp_hold_c%0d: got %h want %h", k, {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, exp_d});
      end
      step();
    end
    rready = 1'b1; step(); rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got %b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] a, b, old_a, v1, v2, d; logic [1:0] wr_r, rd_r; int wl, rl;
    a = BASE + 32'h40; b = BASE + 32'h10;
    v1 = $urandom; v2 = $urandom;
    fork
      axi_write(a, v1, 4'hF, 1'b1, wr_r, wl);
      axi_read(b, d, rd_r, rl);
    join
    checks++; if (wl !== WL + 1) begin errors++; $display("FAIL conc_wlat: got %0d want %0d", wl, WL + 1); end
    checks++; if (rl !== RL + 1) begin errors++; $display("FAIL conc_rlat: got %0d want %0d", rl, RL + 1); end
    checks++; if (d !== ref_read(b)) begin errors++; $display("FAIL conc_rdata: got %h want %h", d, ref_read(b)); end
    // Align the read sample with the write commit on the same word.
    old_a = ref_read(a);
    fork
      axi_write(a, v2, 4'hF, 1'b1, wr_r, wl);
      begin
        repeat (WL - RL) step();
        axi_read(a, d, rd_r, rl);
      end
    join
    checks++; if (d !== old_a) begin errors++; $display("FAIL same_cycle_rdata: got %h want %h", d, old_a); end
    axi_read(a, d, rd_r, rl);
    checks++; if (d !== ref_read(a)) begin errors++; $display("FAIL same_cycle_after: got %h want %h", d, ref_read(a)); end
  endtask

  task automatic test_random();
    logic [31:0] a, v, d; logic [3:0] s; logic [1:0] r; int lat, idx, kind; bit wr;
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'(4 * i);
      axi_write(a, $urandom, 4'hF, 1'b1, r, lat);
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL rnd_init_%0d: got %b want 00", i, r); end
    end
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 15); kind = $urandom_range(0, 7);
      a = BASE + 32'(4 * idx);
      if (kind == 0)      a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * idx);
      else if (kind == 2) a = BASE - 32'(4 * (idx + 1));
      wr = 1'($urandom_range(0, 1)); v = $urandom; s = 4'($urandom_range(0, 15));
      if (wr) axi_write(a, v, s, 1'b1, r, lat);
      else    axi_read(a, d, r, lat);
      checks++;
      if (r !== ref_resp(a)) begin errors++; $display("FAIL rnd_resp_%0d: addr %h got %b want %b", i, a, r, ref_resp(a)); end
      checks++;
      if (lat !== (wr ? WL + 1 : RL + 1)) begin errors++; $display("FAIL rnd_lat_%0d: got %0d want %0d", i, lat, wr ? WL + 1 : RL + 1); end
      if (!wr) begin
        checks++;
        if (d !== ref_read(a)) begin errors++; $display("FAIL rnd_rdata_%0d: addr %h got %h want %h", i, a, d, ref_read(a)); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a, v, d; logic [1:0] r; int lat, n;
    a = BASE + 32'h30; v = $urandom;
    axi_write(a, v, 4'hF, 1'b0, r, lat);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid_pending: got %b want 1", bvalid); end
    araddr = BASE + 32'h10; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step(); arvalid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_out: got %b want 00000", {rvalid, bvalid, arready, awready, wready});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
      errors++; $display("FAIL mid_release: got %b want 00111", {rvalid, bvalid, arready, awready, wready});
    end
    axi_read(a, d, r, lat);
    checks++; if (d !== ref_read(a)) begin errors++; $display("FAIL mid_mem_kept: got %h want %h", d, ref_read(a)); end
    axi_read(BASE + 32'h10, d, r, lat);
    checks++; if (d !== ref_read(BASE + 32'h10)) begin errors++; $display("FAIL mid_mem_kept2: got %h want %h", d, ref_read(BASE + 32'h10)); end
  endtask

  initial begin
    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_w_before_aw();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_sram_responder.md
Name: axil_sram_responder

Overview:
AXI-Lite slave (responder) wrapping a word-organised SRAM array. It is the memory-side end of the instruction-fetch and load/store AXI-Lite masters.
- Serves one read and one write transaction at a time on independent channels.
- Read and write latencies are configurable, with optional pseudo-random extra delay for stress testing.
- Sits between the CPU's AXI-Lite masters (or an arbiter) and the simulated memory.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address mapped to word 0
DEPTH, 1024, number of 32-bit words (power of two)
READ_LATENCY, 1, fixed idle cycles between AR handshake and rvalid (0..15)
WRITE_LATENCY, 1, fixed idle cycles between AW+W capture and bvalid (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response (00 OKAY, 10 SLVERR, 11 DECERR)
rvalid  out  1  read data valid
rready  in  1  master ready for read data
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte lane strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  master ready for write response

Behaviour:
- Reset (rst==0 at posedge clk): all outputs 0; read and write FSMs go to IDLE; latency counters cleared. Any in-flight transaction is dropped. SRAM contents are not cleared.
- The first cycle after reset deasserts sets arready=1, awready=1, wready=1.
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH; index = (addr-BASE_ADDR)>>2.
  - addr[1:0]!=0 -> SLVERR.
  - Out of range -> DECERR (takes priority over SLVERR).
  - Error reads return rdata=0. Error writes do not modify memory.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&&arready, latch araddr, set arready=0, load counter=READ_LATENCY, go to R_WAIT.
  - R_WAIT: decrement the counter each cycle. When it is 0, sample mem[index] into rdata, set rresp, rvalid=1, go to R_RESP.
  - Timing: rvalid rises READ_LATENCY+1 cycles after the AR handshake edge.
  - R_RESP: hold rdata/rresp/rvalid stable until rvalid&&rready. Then rvalid=0, arready=1, go to R_IDLE.
  - Throughput: at most one read every READ_LATENCY+3 cycles.
- Write FSM:
  - W_IDLE: AW and W are accepted independently. Each ready drops after its own handshake; awaddr and wdata/wstrb are latched separately.
  - Once both are captured (same cycle or any order), load counter=WRITE_LATENCY and go to W_WAIT.
  - W_WAIT: decrement; when 0, commit the write (only byte lanes with wstrb[i]=1 updated), set bresp, bvalid=1, go to W_RESP.
  - Timing: bvalid rises WRITE_LATENCY+1 cycles after the later of the two handshakes.
  - W_RESP: hold until bvalid&&bready. Then bvalid=0, awready=wready=1, go to W_IDLE.
- wstrb=0: OKAY response, memory unchanged.
- Same-cycle read sample and write commit to the same word: the read returns the pre-write data.
- Master dropping arvalid/awvalid/wvalid before its handshake is tolerated; nothing is latched.
- Both FSMs run fully concurrently; neither blocks the other.

Optional Feature:
RAND_DELAY_EN:
- When defined, a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11, advanced every cycle, reset to the seed) adds LFSR[2:0] extra cycles. The value is sampled at the moment the counter is loaded, in both R_WAIT and W_WAIT.
- Also, arready/awready/wready in their IDLE states are gated by LFSR[3], producing random backpressure.
- When undefined, latency is exactly the fixed parameter value, readies are unconditionally 1 in IDLE, and no LFSR logic is synthesised.

Test Plan:
- Reset, then write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF and AW/W in the same cycle -> bvalid after WRITE_LATENCY+1 cycles with bresp=00. A read of 32'h8000_0010 then returns 32'hDEADBEEF, rresp=00, rvalid exactly READ_LATENCY+1 cycles after the AR handshake.
- Partial write: wdata 32'h1122_3344 with wstrb=4'b0101 to a word holding 32'hDEADBEEF -> a subsequent read returns 32'hDE22BE44.
- W presented 3 cycles before AW -> wready drops after the W handshake, awready stays 1 until AW arrives, and bvalid appears WRITE_LATENCY+1 cycles after the AW handshake.
- Read 32'h8000_1000 (out of range) -> rresp=11, rdata=0. Write 32'h8000_0002 -> bresp=10 and the word at 32'h8000_0000 is unchanged.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rvalid/rdata stable the whole time, arready stays 0; after the handshake, arready=1 the next cycle.
- Drive rst=0 while in R_WAIT and W_RESP -> rvalid=bvalid=0 the next cycle, then all readies=1. Previously written memory contents are still readable.
